// File: rtl/lcd_hd44780_frame_ctrl_if.sv
// Bundle between the time counters, the HD44780 frame controller and the LCD pins.
//   digits     : BCD digits to display, digit N_DIGITS-1 leftmost in [4*N_DIGITS-1 -: 4]
//   lcd_data   : LCD DB7..DB0
//   lcd_e      : LCD enable strobe
//   lcd_rs     : 0 = command, 1 = data
//   lcd_rw     : read/write select, always write
//   init_done  : power-up init sequence complete
//   frame_done : one-cycle pulse on the E falling edge of a frame's last character
// master: the controller side (drives the LCD pins and status).
// slave : the environment side (drives digits, observes pins and status).
interface lcd_hd44780_frame_ctrl_if #(
  parameter int unsigned N_DIGITS = 6
);
  logic [4*N_DIGITS-1:0] digits;
  logic [7:0]            lcd_data;
  logic                  lcd_e;
  logic                  lcd_rs;
  logic                  lcd_rw;
  logic                  init_done;
  logic                  frame_done;

  modport master (
    input  digits,
    output lcd_data,
    output lcd_e,
    output lcd_rs,
    output lcd_rw,
    output init_done,
    output frame_done
  );

  modport slave (
    output digits,
    input  lcd_data,
    input  lcd_e,
    input  lcd_rs,
    input  lcd_rw,
    input  init_done,
    input  frame_done
  );
endinterface

// File: rtl/lcd_hd44780_frame_ctrl.sv
// HD44780 8-bit write-only controller for the stopwatch/clock display.
// Runs the power-up init sequence (0x38,0x38,0x06,0x0C,0x01), then refreshes an
// N-digit BCD field with ':' separators at a fixed minimum frame period.
// Each frame snapshots the digits, writes 0x80 (DDRAM home), then the characters.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : lcd_hd44780_frame_ctrl_if.master
//            (digits in; lcd_data, lcd_e, lcd_rs, lcd_rw, init_done, frame_done out)
//
// Build option:
//   LCD_LZB_EN : when defined, leading zeros are written as spaces (digit 0 never
//                blanked, '-' counts as nonzero). When undefined, every digit goes
//                through the plain glyph map.
module lcd_hd44780_frame_ctrl #(
  parameter int unsigned         CLK_HZ      = 50_000_000,
  parameter int unsigned         N_DIGITS    = 6,
  parameter logic [N_DIGITS-1:0] SEP_MASK    = 6'b010100,
  parameter logic [7:0]          SEP_CHAR    = 8'h3A,
  parameter int unsigned         T_PWRUP_US  = 20000,
  parameter int unsigned         T_CMD_US    = 40,
  parameter int unsigned         T_CLR_US    = 1640,
  parameter int unsigned         REFRESH_US  = 10000,
  parameter int unsigned         SETUP_CYC   = 4,
  parameter int unsigned         E_PULSE_CYC = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_hd44780_frame_ctrl_if.master    bus
);

  // Microseconds to clock cycles, computed in 64 bits to avoid overflow.
  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned hz);
    longint unsigned c;
    c = (64'(us) * 64'(hz)) / 64'd1_000_000;
    return 32'(c);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Terminal count for an N-cycle wait (timers start at 0).
  function automatic int unsigned cyc_last(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  localparam int unsigned PWRUP_CYC = us2cyc(T_PWRUP_US, CLK_HZ);
  localparam int unsigned CMD_CYC   = us2cyc(T_CMD_US, CLK_HZ);
  localparam int unsigned CLR_CYC   = us2cyc(T_CLR_US, CLK_HZ);
  localparam int unsigned REF_CYC   = us2cyc(REFRESH_US, CLK_HZ);
  localparam int unsigned MAX_CYC   = max2(max2(max2(PWRUP_CYC, CMD_CYC), max2(CLR_CYC, REF_CYC)),
                                           max2(SETUP_CYC, E_PULSE_CYC));
  localparam int unsigned TW        = $clog2(MAX_CYC + 1);
  localparam int unsigned DIW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BW        = 4 * N_DIGITS;

  localparam logic [TW-1:0] PWRUP_LAST = TW'(cyc_last(PWRUP_CYC));
  localparam logic [TW-1:0] CMD_LAST   = TW'(cyc_last(CMD_CYC));
  localparam logic [TW-1:0] CLR_LAST   = TW'(cyc_last(CLR_CYC));
  localparam logic [TW-1:0] REF_LAST   = TW'(cyc_last(REF_CYC));
  localparam logic [TW-1:0] SETUP_LAST = TW'(cyc_last(SETUP_CYC));
  localparam logic [TW-1:0] PULSE_LAST = TW'(cyc_last(E_PULSE_CYC));

  typedef enum logic [1:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_FRAME
  } state_e;

  // Phases of one LCD write: data stable with E low, E high, post-write wait.
  typedef enum logic [1:0] {
    P_SETUP,
    P_PULSE,
    P_WAIT
  } phase_e;

  // Init command list, indexed by position in the sequence.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h38;
      3'd1:    c = 8'h38;
      3'd2:    c = 8'h06;
      3'd3:    c = 8'h0C;
      default: c = 8'h01;
    endcase
    return c;
  endfunction

  // BCD nibble to character: 0..9 as ASCII digits, anything else as '-'.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    return (n <= 4'd9) ? {4'h3, n} : 8'h2D;
  endfunction

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [TW-1:0]   ref_q, ref_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic [DIW-1:0]  dig_q, dig_d;
  logic            sep_next_q, sep_next_d;
  logic            last_q, last_d;
  logic [BW-1:0]   snap_q, snap_d;
  logic [7:0]      lcd_data_q, lcd_data_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic            lcd_e_q, lcd_e_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;
`ifdef LCD_LZB_EN
  logic            seen_nz_q, seen_nz_d;
  logic            blank_c;
`endif

  logic            wr_start_c;
  logic [7:0]      wr_data_c;
  logic            wr_rs_c;
  logic [TW-1:0]   wait_last_c;
  logic [3:0]      nib_c;
  logic [7:0]      dig_char_c;

  // Post-write wait is the long clear-display wait only after command 0x01.
  assign wait_last_c = (!lcd_rs_q && (lcd_data_q == 8'h01)) ? CLR_LAST : CMD_LAST;

  // Character for the digit currently pointed at, taken from the frame snapshot.
  assign nib_c = snap_q[{dig_q, 2'b00} +: 4];

`ifdef LCD_LZB_EN
  // Blank a zero while no nonzero digit has been written yet; digit 0 always shows.
  assign blank_c    = !seen_nz_q && (nib_c == 4'd0) && (dig_q != '0);
  assign dig_char_c = blank_c ? 8'h20 : glyph(nib_c);
`else
  assign dig_char_c = glyph(nib_c);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWRUP;
      phase_q      <= P_SETUP;
      tmr_q        <= '0;
      ref_q        <= '0;
      init_idx_q   <= '0;
      dig_q        <= '0;
      sep_next_q   <= 1'b0;
      last_q       <= 1'b0;
      snap_q       <= '0;
      lcd_data_q   <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_e_q      <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LCD_LZB_EN
      seen_nz_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tmr_q        <= tmr_d;
      ref_q        <= ref_d;
      init_idx_q   <= init_idx_d;
      dig_q        <= dig_d;
      sep_next_q   <= sep_next_d;
      last_q       <= last_d;
      snap_q       <= snap_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_e_q      <= lcd_e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
`ifdef LCD_LZB_EN
      seen_nz_q    <= seen_nz_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tmr_d        = tmr_q + TW'(1);
    // Refresh timer saturates at its terminal count, so it never wraps.
    ref_d        = (ref_q >= REF_LAST) ? ref_q : ref_q + TW'(1);
    init_idx_d   = init_idx_q;
    dig_d        = dig_q;
    sep_next_d   = sep_next_q;
    last_d       = last_q;
    snap_d       = snap_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_e_d      = lcd_e_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
`ifdef LCD_LZB_EN
    seen_nz_d    = seen_nz_q;
`endif
    wr_start_c   = 1'b0;
    wr_data_c    = '0;
    wr_rs_c      = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (tmr_q >= PWRUP_LAST) begin
          state_d    = S_INIT;
          init_idx_d = '0;
          wr_start_c = 1'b1;
          wr_data_c  = init_cmd(3'd0);
        end
      end

      S_IDLE: begin
        tmr_d = '0;
        // Frame start: snapshot digits, restart the period, write DDRAM home.
        if (ref_q >= REF_LAST) begin
          state_d    = S_FRAME;
          ref_d      = '0;
          snap_d     = bus.digits;
          dig_d      = DIW'(N_DIGITS - 1);
          sep_next_d = 1'b0;
          last_d     = 1'b0;
`ifdef LCD_LZB_EN
          seen_nz_d  = 1'b0;
`endif
          wr_start_c = 1'b1;
          wr_data_c  = 8'h80;
        end
      end

      S_INIT, S_FRAME: begin
        case (phase_q)
          P_SETUP: begin
            if (tmr_q >= SETUP_LAST) begin
              phase_d = P_PULSE;
              tmr_d   = '0;
              lcd_e_d = 1'b1;
            end
          end

          P_PULSE: begin
            if (tmr_q >= PULSE_LAST) begin
              phase_d      = P_WAIT;
              tmr_d        = '0;
              lcd_e_d      = 1'b0;
              frame_done_d = (state_q == S_FRAME) && last_q;
            end
          end

          P_WAIT: begin
            if (tmr_q >= wait_last_c) begin
              if (state_q == S_INIT) begin
                if (init_idx_q == 3'd4) begin
                  state_d     = S_IDLE;
                  init_done_d = 1'b1;
                  // First frame follows init without waiting a full period.
                  ref_d       = REF_LAST;
                end else begin
                  init_idx_d = init_idx_q + 3'd1;
                  wr_start_c = 1'b1;
                  wr_data_c  = init_cmd(init_idx_q + 3'd1);
                end
              end else if (last_q) begin
                state_d = S_IDLE;
              end else if (sep_next_q) begin
                sep_next_d = 1'b0;
                wr_start_c = 1'b1;
                wr_rs_c    = 1'b1;
                wr_data_c  = SEP_CHAR;
              end else begin
                // Digit write; a separator follows if this digit's mask bit is set.
                sep_next_d = (dig_q != '0) && SEP_MASK[dig_q];
                last_d     = (dig_q == '0);
                if (dig_q != '0) begin
                  dig_d = dig_q - DIW'(1);
                end
`ifdef LCD_LZB_EN
                if (nib_c != 4'd0) begin
                  seen_nz_d = 1'b1;
                end
`endif
                wr_start_c = 1'b1;
                wr_rs_c    = 1'b1;
                wr_data_c  = dig_char_c;
              end
            end
          end

          default: begin
            phase_d = P_SETUP;
          end
        endcase
      end

      default: begin
        state_d = S_PWRUP;
      end
    endcase

    // Loading a write: data/RS change here and hold until the next load.
    if (wr_start_c) begin
      phase_d    = P_SETUP;
      tmr_d      = '0;
      lcd_data_d = wr_data_c;
      lcd_rs_d   = wr_rs_c;
    end
  end

  assign bus.lcd_data   = lcd_data_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_e      = lcd_e_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_hd44780_frame_ctrl.sv
// Bench for lcd_hd44780_frame_ctrl at CLK_HZ = 1 MHz (1 cycle = 1 us).
// Expected LCD writes are queued as stimulus is applied; a monitor pops and
// compares one entry on every E falling edge. Define LCD_LZB_EN to build the
// bench and design with leading-zero blanking expectations.
module tb_lcd_hd44780_frame_ctrl;
  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned N       = 6;
  localparam int          PWRUP   = 20000;
  localparam int          CMD     = 40;
  localparam int          CLR     = 1640;
  localparam int          REFRESH = 10000;
  localparam int          SETUP   = 4;
  localparam int          EPW     = 12;
  localparam int          GAP     = SETUP + EPW + CMD;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       last;
    int         gap;
    logic       home;
  } wr_t;

  typedef struct {
    logic [23:0] digits;
    logic [63:0] chars;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  lcd_hd44780_frame_ctrl_if #(.N_DIGITS(N)) bus ();

  lcd_hd44780_frame_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t  exp_q[$];
  vec_t vec[4];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_writes = 0;
  int   n_frames = 0;
  int   rise_cyc = 0;
  int   prev_rise_cyc = 0;
  int   home_rise = 0;
  int   fall_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic rs, input logic [7:0] d, input logic last,
                         input int gap, input logic home);
    wr_t w;
    w.rs   = rs;
    w.data = d;
    w.last = last;
    w.gap  = gap;
    w.home = home;
    exp_q.push_back(w);
  endtask

  task automatic push_init();
    logic [7:0] cmds [5];
    cmds = '{8'h38, 8'h38, 8'h06, 8'h0C, 8'h01};
    for (int i = 0; i < 5; i++) push_wr(1'b0, cmds[i], 1'b0, (i == 0) ? 0 : GAP, 1'b0);
  endtask

  task automatic push_frame(input logic [63:0] chars, input logic home_chk);
    push_wr(1'b0, 8'h80, 1'b0, 0, home_chk);
    for (int i = 0; i < 8; i++) push_wr(1'b1, chars[63-8*i -: 8], (i == 7), GAP, 1'b0);
  endtask

  // Release reset and check power-up quiet time, first strobe and init_done timing.
  task automatic bring_up(input logic [63:0] chars);
    int rel;
    int t0;
    push_init();
    push_frame(chars, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    while (bus.lcd_data == 8'h00 && !bus.lcd_e && !bus.lcd_rs && !bus.init_done &&
           (cyc - rel) < 30000) @(negedge clk);
    chk("pwrup_quiet_cycles", cyc - rel, PWRUP);
    chk("first_cmd_data", bus.lcd_data, 8'h38);
    while (!bus.lcd_e && (cyc - rel) < 30000) @(negedge clk);
    chk("first_e_rise_cycle", cyc - rel, PWRUP + SETUP);
    t0 = cyc;
    while (!bus.init_done && (cyc - t0) < 5000) @(negedge clk);
    chk("init_done_after_clr", cyc - fall_cyc, CLR);
  endtask

  // Write monitor: one expected entry consumed per E falling edge.
  initial begin : monitor
    logic e_prev;
    wr_t  w;
    e_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_prev = 1'b0;
      end else begin
        if (bus.frame_done) n_frames++;
        if (bus.lcd_e && !e_prev) begin
          prev_rise_cyc = rise_cyc;
          rise_cyc      = cyc;
        end
        if (!bus.lcd_e && e_prev) begin
          fall_cyc = cyc;
          n_writes++;
          chk("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_rs", bus.lcd_rs, w.rs);
            chk("wr_data", bus.lcd_data, w.data);
            chk("frame_done_at_fall", bus.frame_done, w.last);
            chk("e_high_width", cyc - rise_cyc, EPW);
            if (w.gap != 0) chk("write_spacing", rise_cyc - prev_rise_cyc, w.gap);
            if (w.home) chk("frame_period", rise_cyc - home_rise, REFRESH);
          end
          chk("lcd_rw", bus.lcd_rw, 0);
          if (!bus.lcd_rs && bus.lcd_data == 8'h80) home_rise = rise_cyc;
        end else if (bus.frame_done) begin
          chk("frame_done_stray", bus.frame_done, 0);
        end
        e_prev = bus.lcd_e;
      end
    end
  end

  initial begin : watchdog
    #(10 * 95000);
    $display("FAIL watchdog: run exceeded 95000 cycles (compared %0d, errors %0d)", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int base;
    int nf;

    vec[0] = '{24'h123456, 64'h3132_3A33_343A_3536};
`ifdef LCD_LZB_EN
    vec[1] = '{24'h00A009, 64'h2020_3A2D_303A_3039};
`else
    vec[1] = '{24'h00A009, 64'h3030_3A2D_303A_3039};
`endif
    vec[2] = '{24'h999999, 64'h3939_3A39_393A_3939};
`ifdef LCD_LZB_EN
    vec[3] = '{24'h000105, 64'h2020_3A20_313A_3035};
`else
    vec[3] = '{24'h000105, 64'h3030_3A30_313A_3035};
`endif

    bus.digits = vec[0].digits;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lcd_e", bus.lcd_e, 0);
    chk("rst_lcd_data", bus.lcd_data, 0);
    chk("rst_lcd_rs", bus.lcd_rs, 0);
    chk("rst_lcd_rw", bus.lcd_rw, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_frame_done", bus.frame_done, 0);

    bring_up(vec[0].chars);

    // Change digits after the 3rd character of each frame; the snapshot must hold.
    for (int k = 1; k < 3; k++) begin
      t0 = cyc;
      while (n_writes < 5 + 9 * (k - 1) + 4 && (cyc - t0) < 15000) @(negedge clk);
      chk("third_char_reached", n_writes >= 5 + 9 * (k - 1) + 4, 1);
      bus.digits = vec[k].digits;
      push_frame(vec[k].chars, 1'b1);
      t0 = cyc;
      while (n_frames < k && (cyc - t0) < 15000) @(negedge clk);
      chk("frames_completed", n_frames, k);
    end

    // Asynchronous reset while E is high in the middle of a frame.
    base = n_writes;
    t0 = cyc;
    while ((n_writes < base + 3 || !bus.lcd_e) && (cyc - t0) < 15000) @(negedge clk);
    chk("mid_frame_e_high", bus.lcd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lcd_e", bus.lcd_e, 0);
    chk("async_rst_lcd_data", bus.lcd_data, 0);
    chk("async_rst_lcd_rs", bus.lcd_rs, 0);
    chk("async_rst_init_done", bus.init_done, 0);
    exp_q.delete();
    bus.digits = vec[3].digits;
    repeat (3) @(negedge clk);

    bring_up(vec[3].chars);
    nf = n_frames;
    t0 = cyc;
    while (n_frames == nf && (cyc - t0) < 15000) @(negedge clk);
    chk("post_reset_frame_done", n_frames, nf + 1);
    chk("expected_writes_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
